// File: rtl/if_fetch_unit_if.sv
// Bundle between the instruction fetch unit, the PC generator, the
// instruction bus and decode. The fetch unit uses the master side.
interface if_fetch_unit_if #(
  parameter int AW = 32
);
  logic          pc_valid;
  logic [AW-1:0] pc;
  logic          pc_ready;
  logic          flush;
  logic          inst_req;
  logic          inst_wr;
  logic [1:0]    inst_size;
  logic [AW-1:0] inst_addr;
  logic [31:0]   inst_wdata;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic [31:0]   inst_rdata;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [31:0]   out_inst;
  logic          out_adel;
  logic          out_ready;

  modport master (
    input  pc_valid, pc, flush, inst_addr_ok, inst_data_ok, inst_rdata, out_ready,
    output pc_ready, inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
           out_valid, out_pc, out_inst, out_adel
  );

  modport slave (
    output pc_valid, pc, flush, inst_addr_ok, inst_data_ok, inst_rdata, out_ready,
    input  pc_ready, inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
           out_valid, out_pc, out_inst, out_adel
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues PCs as bus reads, keeps results in program
// order in a slot ring, and drops responses owed to fetches killed by flush.
module if_fetch_unit #(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic            clk,
  input  logic            reset,
  if_fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // Slots are allocated in issue order; the index FIFO maps each bus beat to its slot.
  logic [AW-1:0]    slot_pc_q   [DEPTH];
  logic [31:0]      slot_inst_q [DEPTH];
  logic [DEPTH-1:0] slot_adel_q;
  logic [DEPTH-1:0] slot_done_q;
  ptr_t             idx_q       [DEPTH];

  ptr_t head_q, tail_q, ihead_q, itail_q;
  cnt_t cnt_q, cnt_d, icnt_q, icnt_d, disc_q, disc_d;

  cnt_t credit_s, disc_after_s, icnt_after_s;
  logic aligned_s, take_s, req_s, adel_take_s, push_req_s, push_s;
  logic beat_drop_s, beat_keep_s, valid_s, pop_s;

  always_comb begin
    credit_s     = cnt_q + disc_q;
    aligned_s    = (bus.pc[1:0] == 2'b00);
    take_s       = bus.pc_valid & ~bus.flush & ~reset & (credit_s < cnt_t'(DEPTH));
    req_s        = take_s & aligned_s;
    adel_take_s  = take_s & ~aligned_s;
    push_req_s   = req_s & bus.inst_addr_ok;
    push_s       = push_req_s | adel_take_s;
    beat_drop_s  = bus.inst_data_ok & (disc_q != {CW{1'b0}});
    beat_keep_s  = bus.inst_data_ok & (disc_q == {CW{1'b0}}) & (icnt_q != {CW{1'b0}});
    valid_s      = (cnt_q != {CW{1'b0}}) & slot_done_q[head_q];
    pop_s        = valid_s & bus.out_ready;
    disc_after_s = disc_q - cnt_t'(beat_drop_s);
    icnt_after_s = icnt_q - cnt_t'(beat_keep_s);
    // A flush turns every still-outstanding bus read into a beat to be thrown away.
    if (bus.flush) begin
      cnt_d  = {CW{1'b0}};
      icnt_d = {CW{1'b0}};
      disc_d = disc_after_s + icnt_after_s;
    end else begin
      cnt_d  = cnt_q + cnt_t'(push_s) - cnt_t'(pop_s);
      icnt_d = icnt_after_s + cnt_t'(push_req_s);
      disc_d = disc_after_s;
    end
  end

  assign bus.inst_req   = req_s;
  assign bus.pc_ready   = push_s;
  assign bus.inst_wr    = 1'b0;
  assign bus.inst_size  = 2'b10;
  assign bus.inst_wdata = 32'h0000_0000;
  assign bus.inst_addr  = reset ? {AW{1'b0}} : bus.pc;
  assign bus.out_valid  = valid_s;
  assign bus.out_pc     = valid_s ? slot_pc_q[head_q]   : {AW{1'b0}};
  assign bus.out_inst   = valid_s ? slot_inst_q[head_q] : 32'h0000_0000;
  assign bus.out_adel   = valid_s & slot_adel_q[head_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= {PW{1'b0}};
      tail_q      <= {PW{1'b0}};
      ihead_q     <= {PW{1'b0}};
      itail_q     <= {PW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      icnt_q      <= {CW{1'b0}};
      disc_q      <= {CW{1'b0}};
      slot_adel_q <= {DEPTH{1'b0}};
      slot_done_q <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]   <= {AW{1'b0}};
        slot_inst_q[i] <= 32'h0000_0000;
        idx_q[i]       <= {PW{1'b0}};
      end
    end else begin
      cnt_q  <= cnt_d;
      icnt_q <= icnt_d;
      disc_q <= disc_d;
      if (bus.flush) begin
        head_q  <= {PW{1'b0}};
        tail_q  <= {PW{1'b0}};
        ihead_q <= {PW{1'b0}};
        itail_q <= {PW{1'b0}};
      end else begin
        // Misaligned fetches are complete on entry; aligned ones wait for their beat.
        if (push_s) begin
          slot_pc_q[tail_q]   <= bus.pc;
          slot_inst_q[tail_q] <= 32'h0000_0000;
          slot_adel_q[tail_q] <= ~aligned_s;
          slot_done_q[tail_q] <= ~aligned_s;
          tail_q              <= tail_q + ptr_t'(1'b1);
        end
        if (push_req_s) begin
          idx_q[itail_q] <= tail_q;
          itail_q        <= itail_q + ptr_t'(1'b1);
        end
        if (beat_keep_s) begin
          slot_inst_q[idx_q[ihead_q]] <= bus.inst_rdata;
          slot_done_q[idx_q[ihead_q]] <= 1'b1;
          ihead_q                     <= ihead_q + ptr_t'(1'b1);
        end
        if (pop_s) begin
          head_q <= head_q + ptr_t'(1'b1);
        end
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a bus responder, an in-order reference of
// accepted fetches, and a monitor that pops and compares delivered results.
module tb_if_fetch_unit;
  localparam int DEPTH = 2;
  localparam int AW    = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } beat_t;

  logic clk = 1'b0;
  logic reset;

  if_fetch_unit_if #(.AW(AW)) bus ();

  if_fetch_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  beat_t       bus_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] next_pc;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_inst_req"},  bus.inst_req,  1'b0);
    chk({tag, "_pc_ready"},  bus.pc_ready,  1'b0);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_out_pc"},    bus.out_pc,    32'h0);
    chk({tag, "_out_inst"},  bus.out_inst,  32'h0);
    chk({tag, "_out_adel"},  bus.out_adel,  1'b0);
    chk({tag, "_inst_addr"}, bus.inst_addr, 32'h0);
  endtask

  // One clock of random stimulus; the reference is updated from what was accepted.
  task automatic cycle(input int p_valid, input int p_addr, input int p_data,
                       input int p_ready, input int p_flush, input int p_mis);
    int    outstanding;
    bit    aligned_e;
    bit    take_e;
    exp_t  e;
    beat_t b;
    @(posedge clk);
    #1;
    bus.pc_valid     = ($urandom_range(99) < p_valid);
    bus.pc           = ($urandom_range(99) < p_mis) ? next_pc + 32'd2 : next_pc;
    bus.flush        = ($urandom_range(99) < p_flush);
    bus.out_ready    = ($urandom_range(99) < p_ready);
    bus.inst_addr_ok = ($urandom_range(99) < p_addr);
    if (bus_q.size() > 0 && $urandom_range(99) < p_data) begin
      bus.inst_data_ok = 1'b1;
      bus.inst_rdata   = mem_f(bus_q[0].addr);
    end else begin
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata   = $urandom;
    end
    @(negedge clk);
    // Every accepted fetch holds a credit until delivered or its stale beat returns.
    outstanding = exp_q.size();
    foreach (bus_q[i]) if (bus_q[i].stale) outstanding++;
    aligned_e = (bus.pc[1:0] == 2'b00);
    take_e    = bus.pc_valid && !bus.flush && (outstanding < DEPTH);
    chk("inst_req", bus.inst_req, take_e && aligned_e);
    chk("pc_ready", bus.pc_ready, take_e && (!aligned_e || bus.inst_addr_ok));
    chk("bus_consts", {bus.inst_wr, bus.inst_size, bus.inst_wdata}, {1'b0, 2'b10, 32'h0});
    if (bus.inst_req) chk("inst_addr", bus.inst_addr, bus.pc);
    if (bus.inst_data_ok) void'(bus_q.pop_front());
    if (bus.inst_req && bus.inst_addr_ok) begin
      b.addr  = bus.inst_addr;
      b.stale = 1'b0;
      bus_q.push_back(b);
    end
    if (bus.pc_ready) begin
      e.pc   = bus.pc;
      e.adel = !aligned_e;
      e.inst = aligned_e ? mem_f(bus.pc) : 32'h0;
      exp_q.push_back(e);
      next_pc = next_pc + 32'd4;
    end
    if (bus.flush) begin
      exp_q.delete();
      foreach (bus_q[i]) bus_q[i].stale = 1'b1;
      next_pc = 32'hbfc0_0380;
    end
  endtask

  // Monitor: whenever decode sees a valid result, compare it with the oldest expected.
  initial begin
    bit   prev_flush;
    exp_t e;
    prev_flush = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        prev_flush = 1'b0;
      end else begin
        if (prev_flush) chk("valid_after_flush", bus.out_valid, 1'b0);
        if (bus.out_valid && !bus.flush) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out_valid", bus.out_valid, 1'b0);
          end else begin
            e = exp_q[0];
            chk("out_pc",   bus.out_pc,   e.pc);
            chk("out_inst", bus.out_inst, e.inst);
            chk("out_adel", bus.out_adel, e.adel);
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end
        prev_flush = bus.flush;
      end
    end
  end

  initial begin
    reset            = 1'b1;
    next_pc          = 32'hbfc0_0000;
    bus.pc_valid     = 1'b1;
    bus.pc           = 32'hbfc0_0000;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b1;
    bus.inst_addr_ok = 1'b1;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'h0;
    #1;
    chk_quiet("reset");
    bus.pc_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    repeat (12)  cycle(100, 100, 100, 100, 0, 0);
    repeat (8)   cycle(100, 100, 100, 0,   0, 0);
    repeat (6)   cycle(100, 100, 100, 100, 0, 50);
    repeat (400) cycle(70,  60,  60,  60,  4, 8);
    repeat (200) cycle(80,  80,  80,  80,  25, 15);

    // Fill up with results held back by decode, then reset in the middle of a cycle.
    repeat (6) cycle(100, 100, 100, 0, 0, 0);
    @(posedge clk);
    #1;
    bus.pc_valid     = 1'b1;
    bus.pc           = next_pc;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b1;
    bus.inst_addr_ok = 1'b1;
    bus.inst_data_ok = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_quiet("reset_mid");
    exp_q.delete();
    bus_q.delete();
    next_pc      = 32'hbfc0_0000;
    bus.pc_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    repeat (300) cycle(70, 60, 60, 60, 5, 10);
    repeat (40)  cycle(0, 100, 100, 100, 0, 0);
    chk("drain_left", exp_q.size(), 0);
    chk("drain_out_valid", bus.out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
